// File: rtl/coffee_vending_machine.sv
// Single-product coffee vending controller.
// Counts one-unit coins into a saturating credit register (held as FSM states
// S0..S3), dispenses a coffee when buy is pressed with enough credit, and
// rejects coins that arrive while the machine is already full.
// Both actuator pulses are registered and last exactly one cycle per event.
module coffee_vending_machine #(
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 3,
  parameter int CREDIT_W   = 2
) (
  input  logic clk,
  input  logic rst_n,        // synchronous, active-high: 1 = reset
  input  logic coin,
  input  logic buy,
  output logic coffee,
  output logic coin_return
);

  // One state per credit value; the encoding equals the credit count so the
  // next-state arithmetic can work directly on the state value.
  typedef enum logic [CREDIT_W-1:0] {
    S0 = CREDIT_W'(0),
    S1 = CREDIT_W'(1),
    S2 = CREDIT_W'(2),
    S3 = CREDIT_W'(3)
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDIT);

  state_t              state;
  state_t              state_next;
  logic                coffee_next;
  logic                return_next;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] credit_after_buy;
  logic                purchase;

  assign credit = state;

  // State register and registered pulse outputs; reset overrides coin/buy.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values, regardless of statement order.
    if (rst_n) begin
      state       <= S0;
      coffee      <= 1'b0;
      coin_return <= 1'b0;
    end else begin
      state       <= state_next;
      coffee      <= coffee_next;
      coin_return <= return_next;
    end
  end

  // Next-state and next-output decode: purchase first, then coin handling.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    purchase         = 1'b0;
    credit_after_buy = credit;
    coffee_next      = 1'b0;
    return_next      = 1'b0;
    state_next       = state;

    // Purchase is judged on the credit held before the edge, so a coin in
    // the same cycle never helps pay for this coffee.
    if (buy && (credit >= PRICE_C)) begin
      purchase         = 1'b1;
      credit_after_buy = credit - PRICE_C;
    end
    coffee_next = purchase;

    // A purchase at full credit frees room, so the coin is checked against
    // the post-purchase credit; coffee and return therefore never coincide.
    if (coin) begin
      if (credit_after_buy < MAX_C) begin
        state_next = state_t'(credit_after_buy + CREDIT_W'(1));
      end else begin
        state_next  = state_t'(MAX_C);
        return_next = 1'b1;
      end
    end else begin
      state_next = state_t'(credit_after_buy);
    end
  end

endmodule

// File: tb/tb_coffee_vending_machine.sv
// Directed testbench for coffee_vending_machine with a scoreboard.
// Each step drives inputs, pushes the reference model's expected pulses to a
// queue, and pops/compares them just after the rising edge.
module tb_coffee_vending_machine;

  localparam int PRICE      = 3;
  localparam int MAX_CREDIT = 3;

  typedef struct {
    string tag;
    logic  coffee;
    logic  ret;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic coin = 1'b0;
  logic buy = 1'b0;
  logic coffee;
  logic coin_return;

  int   checks = 0;
  int   errors = 0;
  int   model_credit = 0;
  exp_t sb_q[$];

  coffee_vending_machine #(
    .PRICE(PRICE),
    .MAX_CREDIT(MAX_CREDIT),
    .CREDIT_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .coin(coin),
    .buy(buy),
    .coffee(coffee),
    .coin_return(coin_return)
  );

  always #5 clk = ~clk;

  // Reference model of one edge; returns the expected pulses.
  task automatic model_edge(input logic r, input logic c, input logic b,
                            output logic e_coffee, output logic e_ret);
    int after;
    e_coffee = 1'b0;
    e_ret    = 1'b0;
    if (r) begin
      model_credit = 0;
    end else begin
      after = model_credit;
      if (b && model_credit >= PRICE) begin
        e_coffee = 1'b1;
        after    = model_credit - PRICE;
      end
      if (c) begin
        if (after < MAX_CREDIT) after = after + 1;
        else e_ret = 1'b1;
      end
      model_credit = after;
    end
  endtask

  // Drive one edge's inputs, predict, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic c, input logic b);
    exp_t e;
    logic ec, er;
    @(negedge clk);
    rst_n = r;
    coin  = c;
    buy   = b;
    model_edge(r, c, b, ec, er);
    e.tag = tag;
    e.coffee = ec;
    e.ret = er;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    assert (coffee === e.coffee) else begin
      errors++;
      $error("FAIL %s coffee observed=%b expected=%b", e.tag, coffee, e.coffee);
    end
    checks++;
    assert (coin_return === e.ret) else begin
      errors++;
      $error("FAIL %s return observed=%b expected=%b", e.tag, coin_return, e.ret);
    end
  endtask

  initial begin
    // 1. Reset overrides coin and buy.
    step("reset", 1'b1, 1'b1, 1'b1);
    step("post_reset_idle", 1'b0, 1'b0, 1'b0);
    // Credit is zero after reset: a buy must not dispense.
    step("buy_at_zero", 1'b0, 1'b0, 1'b1);

    // 2. Accumulate to 3, then buy.
    step("acc_coin1", 1'b0, 1'b1, 1'b0);
    step("acc_coin2", 1'b0, 1'b1, 1'b0);
    step("acc_coin3", 1'b0, 1'b1, 1'b0);
    step("acc_buy", 1'b0, 1'b0, 1'b1);
    step("acc_after_buy", 1'b0, 1'b0, 1'b0);
    step("acc_buy_empty", 1'b0, 1'b0, 1'b1);

    // 3. Early buy with coin from credit 1 -> credit 2, no coffee.
    step("early_coin", 1'b0, 1'b1, 1'b0);
    step("early_coin_buy", 1'b0, 1'b1, 1'b1);
    step("early_buy_at2", 1'b0, 1'b0, 1'b1);
    step("early_coin3", 1'b0, 1'b1, 1'b0);

    // 4. Overflow reject at full credit, then buy.
    step("ovf_coin1", 1'b0, 1'b1, 1'b0);
    step("ovf_coin2", 1'b0, 1'b1, 1'b0);
    step("ovf_buy", 1'b0, 1'b0, 1'b1);

    // 5. Buy at full credit with coin -> coffee, credit 1.
    step("full_fill1", 1'b0, 1'b1, 1'b0);
    step("full_fill2", 1'b0, 1'b1, 1'b0);
    step("full_fill3", 1'b0, 1'b1, 1'b0);
    step("full_coin_buy", 1'b0, 1'b1, 1'b1);
    step("full_coin_a", 1'b0, 1'b1, 1'b0);
    step("full_coin_b", 1'b0, 1'b1, 1'b0);
    step("full_coin_reject", 1'b0, 1'b1, 1'b0);
    step("full_buy", 1'b0, 1'b0, 1'b1);

    // Mid-operation reset discards credit without refund.
    step("midrst_coin1", 1'b0, 1'b1, 1'b0);
    step("midrst_coin2", 1'b0, 1'b1, 1'b0);
    step("midrst_reset", 1'b1, 1'b0, 1'b0);
    step("midrst_coin", 1'b0, 1'b1, 1'b0);
    step("midrst_buy", 1'b0, 1'b0, 1'b1);

    // 6. Full sequence from zero credit.
    step("seq_clear", 1'b1, 1'b0, 1'b0);
    step("seq_e1_coin", 1'b0, 1'b1, 1'b0);
    step("seq_e2_coin_buy", 1'b0, 1'b1, 1'b1);
    step("seq_e3_coin", 1'b0, 1'b1, 1'b0);
    step("seq_e4_coin", 1'b0, 1'b1, 1'b0);
    step("seq_e5_coin", 1'b0, 1'b1, 1'b0);
    step("seq_e6_buy", 1'b0, 1'b0, 1'b1);
    step("seq_e7_coin", 1'b0, 1'b1, 1'b0);
    step("seq_e8_coin", 1'b0, 1'b1, 1'b0);
    step("seq_e9_coin", 1'b0, 1'b1, 1'b0);
    step("seq_e10_buy", 1'b0, 1'b0, 1'b1);
    step("seq_e11_idle", 1'b0, 1'b0, 1'b0);
    // Final credit is zero: a further buy must not dispense.
    step("seq_final_buy", 1'b0, 1'b0, 1'b1);

    // Short randomized tail against the model.
    for (int i = 0; i < 40; i++) begin
      step("rand", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coffee_vending_machine.md
Name: coffee_vending_machine

Overview:
Single-product coffee vending controller that counts one-unit coins and dispenses a coffee when enough credit has accumulated and buy is pressed. Excess coins are rejected. It sits between the coin-acceptor/button front end and the dispense/return actuators. Pulse outputs are registered; there is one clock domain.

Parameters:
PRICE, 3, coin units consumed per coffee (must satisfy 1 <= PRICE <= MAX_CREDIT)
MAX_CREDIT, 3, maximum credit the machine holds; coins beyond this are returned
CREDIT_W, 2, width of the internal credit register (must hold MAX_CREDIT)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  reset; synchronous, active-high despite the name; 1 = reset
coin  input  1  one-unit coin present this cycle; sampled each rising edge, each high cycle = one coin
buy  input  1  buy request; sampled each rising edge, level-sampled with no edge detection
coffee  output  1  registered one-cycle dispense pulse
return  output  1  registered one-cycle coin-reject pulse

Behaviour:
- Reset: on a rising edge with rst_n=1, credit=0, coffee=0, return=0. Reset overrides coin and buy in that cycle. Reset mid-operation discards accumulated credit without refund.
- State: credit register 0..MAX_CREDIT, implemented as FSM states S0..S<MAX_CREDIT> (default S0,S1,S2,S3).
- On each non-reset edge, let c = credit before the edge. Evaluate in this order:
  - Purchase: if buy=1 and c >= PRICE, then coffee<=1 and c' = c - PRICE. Otherwise coffee<=0 and c' = c.
  - Coin: if coin=1 and c' < MAX_CREDIT, credit <= c'+1 and return<=0.
  - Coin at full credit: if coin=1 and c' == MAX_CREDIT, credit stays at MAX_CREDIT and return<=1 (coin rejected).
  - No coin: credit <= c', return<=0.
- Buy with insufficient credit (c < PRICE) is ignored: no coffee, no return, no credit change. A coin in the same cycle is still accepted.
- A simultaneous coin and buy does not count the current coin toward that purchase. The purchase is checked against the credit before the edge.
- coffee and return are each high for exactly one cycle per event. Both change only on rising edges. Both are low in every cycle with no qualifying event.
- coffee and return can never both be 1. A purchase at full credit frees space, so a simultaneous coin is accepted.
- Latency: an input sampled at edge N is reflected in credit, coffee and return immediately after edge N.
- No arithmetic overflow or underflow: credit saturates at MAX_CREDIT and never goes below 0.

Test Plan:
1. Reset: rst_n=1 for one edge with coin=1, buy=1 -> credit=0, coffee=0, return=0 after the edge. Then rst_n=0.
2. Accumulate and buy: coin=1 for 3 edges (credit 1,2,3), then buy=1 alone -> coffee=1 for exactly one cycle, credit=0, return=0 throughout.
3. Early buy with coin: from credit=1, drive coin=1 and buy=1 for one edge -> no coffee, credit=2, return=0.
4. Overflow reject: from credit=3, coin=1 for 2 edges -> return=1 on each of those cycles, credit stays 3, coffee=0. Then buy=1 -> coffee=1, credit=0.
5. Buy at full credit with coin: credit=3, coin=1 and buy=1 -> coffee=1, return=0, credit=1.
6. Full sequence (one edge each): coin; coin+buy; coin x3; buy; coin x3; buy; idle -> coffee pulses at edges 6 and 10, return pulses at edges 4 and 5, final credit=0.
